bus_wait_ctrl: RTL and testbench

//  Downstream of the 4510 mapper. Decodes the mapper's 20-bit next-cycle physical address into one-hot

---
 rtl/bus_wait_ctrl.sv | 87 ++++++++
 tb/tb_bus_wait_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_ctrl.sv
// bus_wait_ctrl: region decode, per-region wait states and handshaked external bus sequencing
module bus_wait_ctrl #(
    parameter int unsigned WS_RAM      = 0,
    parameter int unsigned WS_ROM      = 1,
    parameter int unsigned WS_IO       = 2,
    parameter int unsigned EXT_TIMEOUT = 64,
    parameter logic [7:0]  IO_PAGE     = 8'h0D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] address_next,
    input  logic        map_next,
    input  logic        we_next,
    input  logic        ext_ack,
    output logic        ready,
    output logic        cs_ram,
    output logic        cs_rom,
    output logic        cs_io,
    output logic        cs_ext,
    output logic        bus_we,
    output logic        bus_error
);
    typedef enum logic {RUN, EXT_WAIT} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [7:0]  tmo;
    logic        dec_io, dec_ext, dec_rom, dec_ram, tmo_end;
    logic [3:0]  ws_sel;

    // Region decode of the mapper's next-cycle address, I/O page wins only when unmapped
    always_comb begin
        dec_io  = !map_next && address_next[19:12] == IO_PAGE;
        dec_ext = !dec_io && address_next[19];
        dec_rom = !dec_io && !dec_ext && address_next[19:17] == 3'b001;
        dec_ram = !dec_io && !dec_ext && !dec_rom;
        ws_sel  = dec_io ? 4'(WS_IO) : dec_rom ? 4'(WS_ROM) : 4'(WS_RAM);
        tmo_end = tmo == 8'(EXT_TIMEOUT - 1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    // Next state: enter EXT_WAIT on an external accept, leave on ack or timeout
    always_comb begin
        state_nx = state;
        if (state == RUN) state_nx = (ready && dec_ext) ? EXT_WAIT : RUN;
        else if (ext_ack || tmo_end) state_nx = RUN;
    end

    // Output: ready depends on registered state only
    always_comb begin
        ready = state == RUN && cnt == 4'd0;
    end

    // Datapath: selects and write strobe latch on accept, counters run between accepts
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 4'd0;
            tmo       <= 8'd0;
            cs_ram    <= 1'b0;
            cs_rom    <= 1'b0;
            cs_io     <= 1'b0;
            cs_ext    <= 1'b0;
            bus_we    <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            bus_error <= state == EXT_WAIT && !ext_ack && tmo_end;
            if (ready) begin
                cs_ram <= dec_ram;
                cs_rom <= dec_rom;
                cs_io  <= dec_io;
                cs_ext <= dec_ext;
                bus_we <= we_next && !dec_rom;
                cnt    <= dec_ext ? 4'd0 : ws_sel;
                tmo    <= 8'd0;
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
            end else begin
                tmo <= tmo + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_bus_wait_ctrl.sv
// tb_bus_wait_ctrl: directed scenario checks of bus_wait_ctrl with default parameters
module tb_bus_wait_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] address_next = 20'h01234;
    logic        map_next = 1'b0;
    logic        we_next = 1'b0;
    logic        ext_ack = 1'b0;
    logic        ready, cs_ram, cs_rom, cs_io, cs_ext, bus_we, bus_error;
    logic [6:0]  obs;
    int          checks = 0;
    int          errors = 0;

    localparam logic [19:0] A_RAM = 20'h01234;
    localparam logic [19:0] A_IO  = 20'h0D020;
    localparam logic [19:0] A_ROM = 20'h20000;
    localparam logic [19:0] A_EXT = 20'h80000;

    bus_wait_ctrl dut (
        .clk(clk), .reset(reset), .address_next(address_next), .map_next(map_next),
        .we_next(we_next), .ext_ack(ext_ack), .ready(ready), .cs_ram(cs_ram),
        .cs_rom(cs_rom), .cs_io(cs_io), .cs_ext(cs_ext), .bus_we(bus_we), .bus_error(bus_error)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Packed view {ready, cs_ram, cs_rom, cs_io, cs_ext, bus_we, bus_error}
    assign obs = {ready, cs_ram, cs_rom, cs_io, cs_ext, bus_we, bus_error};

    task automatic test_reset;
        reset = 1'b1;
        address_next = A_RAM;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 7'b1000000) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, 7'b1000000); end
        reset = 1'b0;
    endtask

    task automatic test_ram;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 7'b1100000) begin errors++; $display("FAIL ram_zero_ws[%0d]: got %b expected %b", i, obs, 7'b1100000); end
        end
    endtask

    task automatic test_io;
        logic [6:0] exp_io [3] = '{7'b0001000, 7'b0001000, 7'b1001000};
        address_next = A_IO;
        map_next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_io[i]) begin errors++; $display("FAIL io_wait[%0d]: got %b expected %b", i, obs, exp_io[i]); end
        end
        map_next = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 7'b1100000) begin errors++; $display("FAIL io_mapped_ram[%0d]: got %b expected %b", i, obs, 7'b1100000); end
        end
        map_next = 1'b0;
    endtask

    task automatic test_rom_write;
        address_next = A_ROM;
        we_next = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0010000) begin errors++; $display("FAIL rom_write_wait: got %b expected %b", obs, 7'b0010000); end
        @(negedge clk);
        checks++;
        if (obs !== 7'b1010000) begin errors++; $display("FAIL rom_write_done: got %b expected %b", obs, 7'b1010000); end
        address_next = A_RAM;
        @(negedge clk);
        checks++;
        if (obs !== 7'b1100010) begin errors++; $display("FAIL ram_write: got %b expected %b", obs, 7'b1100010); end
        we_next = 1'b0;
    endtask

    task automatic test_ext_ack;
        address_next = A_EXT;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 7'b0000100) begin errors++; $display("FAIL ext_wait[%0d]: got %b expected %b", i, obs, 7'b0000100); end
        end
        ext_ack = 1'b1;
        @(negedge clk);
        ext_ack = 1'b0;
        checks++;
        if (obs !== 7'b1000100) begin errors++; $display("FAIL ext_ack_done: got %b expected %b", obs, 7'b1000100); end
    endtask

    task automatic test_ext_timeout;
        int n = 0;
        int early = 0;
        address_next = A_EXT;
        @(negedge clk);
        while (ready === 1'b0 && n < 200) begin
            if (bus_error !== 1'b0) early++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 64) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", n, 64); end
        checks++;
        if (early != 0) begin errors++; $display("FAIL timeout_early_err: got %0d expected %0d", early, 0); end
        checks++;
        if (obs !== 7'b1000101) begin errors++; $display("FAIL timeout_pulse: got %b expected %b", obs, 7'b1000101); end
        address_next = A_RAM;
        @(negedge clk);
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL timeout_after: got %b expected %b", obs, 7'b1100000); end
    endtask

    task automatic test_ack_at_terminal;
        address_next = A_EXT;
        repeat (64) @(negedge clk);
        checks++;
        if (obs !== 7'b0000100) begin errors++; $display("FAIL terminal_wait: got %b expected %b", obs, 7'b0000100); end
        ext_ack = 1'b1;
        @(negedge clk);
        ext_ack = 1'b0;
        checks++;
        if (obs !== 7'b1000100) begin errors++; $display("FAIL ack_wins: got %b expected %b", obs, 7'b1000100); end
        address_next = A_RAM;
        @(negedge clk);
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL ack_wins_after: got %b expected %b", obs, 7'b1100000); end
    endtask

    task automatic test_reset_mid;
        address_next = A_IO;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 7'b0001000) begin errors++; $display("FAIL io_before_reset: got %b expected %b", obs, 7'b0001000); end
        reset = 1'b1;
        address_next = A_RAM;
        @(negedge clk);
        checks++;
        if (obs !== 7'b1000000) begin errors++; $display("FAIL reset_mid_io: got %b expected %b", obs, 7'b1000000); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL after_reset_io: got %b expected %b", obs, 7'b1100000); end
        address_next = A_EXT;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 7'b0000100) begin errors++; $display("FAIL ext_before_reset: got %b expected %b", obs, 7'b0000100); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 7'b1000000) begin errors++; $display("FAIL reset_mid_ext: got %b expected %b", obs, 7'b1000000); end
        reset = 1'b0;
        address_next = A_RAM;
        @(negedge clk);
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL after_reset_ext: got %b expected %b", obs, 7'b1100000); end
    endtask

    task automatic test_ack_in_run;
        logic [6:0] exp_io [3] = '{7'b0001000, 7'b0001000, 7'b1001000};
        ext_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 7'b1100000) begin errors++; $display("FAIL ack_idle[%0d]: got %b expected %b", i, obs, 7'b1100000); end
        end
        address_next = A_IO;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_io[i]) begin errors++; $display("FAIL ack_during_io[%0d]: got %b expected %b", i, obs, exp_io[i]); end
        end
        ext_ack = 1'b0;
        address_next = A_RAM;
        @(negedge clk);
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL ack_run_after: got %b expected %b", obs, 7'b1100000); end
    endtask

    // Scenario sequence
    initial begin
        test_reset;
        test_ram;
        test_io;
        test_rom_write;
        test_ext_ack;
        test_ext_timeout;
        test_ack_at_terminal;
        test_reset_mid;
        test_ack_in_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
